// File: rtl/coin_feeder.sv
// coin_feeder: drives a greedy sequence of one-cycle coin pulses (in5/in2/in1)
// into the vending FSM for a requested amount. It also counts the sodas and
// the change units that the FSM reports while the sequence runs.
// Ports: clk/rst_n (sync active-low); start/amount request; in1/in2/in5 coin pulses;
//        soda/out1/out2/out2x2 FSM responses; busy/done status; soda_cnt/change_sum results.
// All outputs are registered. The first pulse appears in the cycle after start is accepted.
module coin_feeder #(
  parameter int AMT_W  = 4,
  parameter int GAP    = 2,
  parameter int SODA_W = 4,
  parameter int CHG_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AMT_W-1:0]  amount,
  output logic              in1,
  output logic              in2,
  output logic              in5,
  input  logic              soda,
  input  logic              out1,
  input  logic              out2,
  input  logic              out2x2,
  output logic              busy,
  output logic              done,
  output logic [SODA_W-1:0] soda_cnt,
  output logic [CHG_W-1:0]  change_sum
);

  localparam int GW = (GAP < 2) ? 1 : $clog2(GAP + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  state_t           state, next_state;
  logic [AMT_W-1:0] remaining;
  logic [GW-1:0]    gap_cnt;

  // Coin choice for the pulse about to be registered. When a run starts, the
  // choice is made straight from `amount`, so the first pulse appears
  // without an extra cycle.
  logic [AMT_W-1:0] sel_src;
  logic [AMT_W-1:0] coin_val;
  logic             sel5, sel2;

  logic nxt_in1, nxt_in2, nxt_in5, nxt_busy, nxt_done;

  logic                 sample;
  logic [CHG_W:0]       chg_ext;
  logic [2:0]           chg_add;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start) next_state = (amount == '0) ? ST_FIN : ST_PULSE;
      ST_PULSE: next_state = ST_GAP;
      ST_GAP:   if (gap_cnt == GW'(1))
                  next_state = (remaining != '0) ? ST_PULSE : ST_FIN;
      ST_FIN:   next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Greedy coin selection
  always_comb begin
    sel_src  = (state == ST_IDLE) ? amount : remaining;
    sel5     = (sel_src >= AMT_W'(5));
    sel2     = (sel_src >= AMT_W'(2));
    coin_val = sel5 ? AMT_W'(5) : (sel2 ? AMT_W'(2) : AMT_W'(1));
  end

  // Output logic: computed from the next state and registered below.
  always_comb begin
    nxt_in5  = (next_state == ST_PULSE) && sel5;
    nxt_in2  = (next_state == ST_PULSE) && !sel5 && sel2;
    nxt_in1  = (next_state == ST_PULSE) && !sel5 && !sel2;
    nxt_busy = (next_state == ST_PULSE) || (next_state == ST_GAP);
    nxt_done = (next_state == ST_FIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in1  <= 1'b0;
      in2  <= 1'b0;
      in5  <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      in1  <= nxt_in1;
      in2  <= nxt_in2;
      in5  <= nxt_in5;
      busy <= nxt_busy;
      done <= nxt_done;
    end
  end

  // Remaining amount is decremented at the same edge that registers the
  // pulse, so it already reflects the coin that is being shown.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      remaining <= '0;
    end else if (next_state == ST_PULSE) begin
      remaining <= sel_src - coin_val;
    end else if (state == ST_IDLE && start) begin
      remaining <= amount;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                gap_cnt <= '0;
    else if (state == ST_PULSE) gap_cnt <= GW'(GAP);
    else if (state == ST_GAP)   gap_cnt <= gap_cnt - GW'(1);
  end

  // Response counters. The change lines use weights 4/2/1, which are exactly
  // the binary weights of {out2x2, out2, out1}.
  always_comb begin
    sample  = (state == ST_PULSE) || (state == ST_GAP);
    chg_add = {out2x2, out2, out1};
    chg_ext = {1'b0, change_sum} + (CHG_W+1)'(chg_add);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      soda_cnt   <= '0;
      change_sum <= '0;
    end else if (state == ST_IDLE && start) begin
      soda_cnt   <= '0;
      change_sum <= '0;
    end else if (sample) begin
      if (soda && soda_cnt != '1)
        soda_cnt <= soda_cnt + SODA_W'(1);
      change_sum <= chg_ext[CHG_W] ? '1 : chg_ext[CHG_W-1:0];
    end
  end

endmodule
